konami2_bus_initiator: RTL and testbench

- CPU-side bus cycle sequencer for the Konami-2 system bus: the initiator end of the AS/DTAC handshake that the board's address decoder and bus-control logic answer.
- Accepts single read/write requests from an internal master (debug port, DMA, or CPU-replacement test harness) and drives ADR, BK4, RW, data and AS.
- Waits for the responder's DTAC, captures read data and returns ACK.
- Runs on SYSCLK; advances only on the CK12_CE enable.

---
 rtl/konami2_bus_initiator_if.sv | 33 +++
 rtl/konami2_bus_initiator.sv | 162 ++++++++++++++++
 tb/tb_konami2_bus_initiator.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/konami2_bus_initiator_if.sv
// Request and bus-side signals of the Konami-2 initiator, as one bundle.
// The master modport is the initiator; the slave modport is the requester plus responder side.
interface konami2_bus_initiator_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              REQ;
    logic              REQ_WE;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic              REQ_BK4;
    logic [DATA_W-1:0] REQ_WDATA;
    logic              ACK;
    logic [DATA_W-1:0] RDATA;
    logic              TOUT;
    logic              AS;
    logic [ADDR_W-1:0] ADR;
    logic              BK4;
    logic              RW;
    logic [DATA_W-1:0] DOUT;
    logic              DOE;
    logic [DATA_W-1:0] DIN;
    logic              DTAC;

    modport master (
        input  REQ, REQ_WE, REQ_ADDR, REQ_BK4, REQ_WDATA, DIN, DTAC,
        output ACK, RDATA, TOUT, AS, ADR, BK4, RW, DOUT, DOE
    );

    modport slave (
        output REQ, REQ_WE, REQ_ADDR, REQ_BK4, REQ_WDATA, DIN, DTAC,
        input  ACK, RDATA, TOUT, AS, ADR, BK4, RW, DOUT, DOE
    );
endinterface

// File: rtl/konami2_bus_initiator.sv
// Konami-2 bus initiator: runs one AS/DTAC cycle per request, advancing only on CK12_CE ticks.
// Define KONAMI2_INIT_TIMEOUT_EN to bound WAIT and RELEASE with a tick counter (sets TOUT).
module konami2_bus_initiator #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int TIMEOUT_TICKS = 255
) (
    input  logic SYSCLK,
    input  logic RESET,
    input  logic CK12_CE,
    konami2_bus_initiator_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_RELEASE} state_e;

    if (TIMEOUT_TICKS < 1) begin : g_bad_timeout
        $error("TIMEOUT_TICKS must be at least 1");
    end

    state_e            state_q, state_d;
    logic              as_q, as_d;
    logic              rw_q, rw_d;
    logic              bk4_q, bk4_d;
    logic              doe_q, doe_d;
    logic              ack_q, ack_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef KONAMI2_INIT_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tout_q, tout_d;
    logic             expired;

    // Counter holds ticks already spent in the state, so this is the TIMEOUT_TICKS-th tick.
    assign expired = (cnt_q == CNT_LAST);
`endif

    always_comb begin
        state_d = state_q;
        as_d    = as_q;
        rw_d    = rw_q;
        bk4_d   = bk4_q;
        doe_d   = doe_q;
        adr_d   = adr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
`ifdef KONAMI2_INIT_TIMEOUT_EN
        cnt_d   = cnt_q;
        tout_d  = tout_q;
`endif
        if (CK12_CE) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.REQ) begin
                        adr_d   = bus.REQ_ADDR;
                        bk4_d   = bus.REQ_BK4;
                        rw_d    = ~bus.REQ_WE;
                        dout_d  = bus.REQ_WDATA;
                        state_d = S_SETUP;
`ifdef KONAMI2_INIT_TIMEOUT_EN
                        tout_d  = 1'b0;
`endif
                    end
                end
                // DTAC is not looked at here: a level left low by the previous cycle is stale.
                S_SETUP: begin
                    as_d    = 1'b0;
                    doe_d   = ~rw_q;
                    state_d = S_WAIT;
`ifdef KONAMI2_INIT_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
                S_WAIT: begin
                    if (!bus.DTAC) begin
                        if (rw_q) rdata_d = bus.DIN;
                        as_d    = 1'b1;
                        state_d = S_RELEASE;
`ifdef KONAMI2_INIT_TIMEOUT_EN
                        cnt_d   = '0;
                    end else if (expired) begin
                        if (rw_q) rdata_d = '1;
                        as_d    = 1'b1;
                        tout_d  = 1'b1;
                        state_d = S_RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
`endif
                    end
                end
                // AS is already high; DOE and ADR stay put until the responder lets go of DTAC.
                S_RELEASE: begin
                    if (bus.DTAC) begin
                        doe_d   = 1'b0;
                        ack_d   = 1'b1;
                        state_d = S_IDLE;
`ifdef KONAMI2_INIT_TIMEOUT_EN
                    end else if (expired) begin
                        doe_d   = 1'b0;
                        ack_d   = 1'b1;
                        tout_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            as_q    <= 1'b1;
            rw_q    <= 1'b1;
            bk4_q   <= 1'b0;
            doe_q   <= 1'b0;
            ack_q   <= 1'b0;
            adr_q   <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
`ifdef KONAMI2_INIT_TIMEOUT_EN
            cnt_q   <= '0;
            tout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            as_q    <= as_d;
            rw_q    <= rw_d;
            bk4_q   <= bk4_d;
            doe_q   <= doe_d;
            ack_q   <= ack_d;
            adr_q   <= adr_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
`ifdef KONAMI2_INIT_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
`endif
        end
    end

    assign bus.AS    = as_q;
    assign bus.ADR   = adr_q;
    assign bus.BK4   = bk4_q;
    assign bus.RW    = rw_q;
    assign bus.DOUT  = dout_q;
    assign bus.DOE   = doe_q;
    assign bus.ACK   = ack_q;
    assign bus.RDATA = rdata_q;
`ifdef KONAMI2_INIT_TIMEOUT_EN
    assign bus.TOUT  = tout_q;
`else
    assign bus.TOUT  = 1'b0;
`endif
endmodule

// File: tb/tb_konami2_bus_initiator.sv
// Bench for konami2_bus_initiator: directed requests against a behavioural DTAC responder,
// with a scoreboard of expected RDATA/TOUT popped by a monitor on every ACK.
module tb_konami2_bus_initiator;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TT = 8;

    logic SYSCLK  = 1'b0;
    logic RESET   = 1'b1;
    logic CK12_CE = 1'b0;

    konami2_bus_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    konami2_bus_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_TICKS(TT)) dut (
        .SYSCLK (SYSCLK),
        .RESET  (RESET),
        .CK12_CE(CK12_CE),
        .bus    (bus)
    );

    always #5 SYSCLK = ~SYSCLK;

    int errors = 0;
    int checks = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // CK12_CE generator: one tick every ce_div SYSCLK cycles
    int ce_div = 1;
    int ce_cnt = 0;
    initial forever begin
        @(negedge SYSCLK);
        ce_cnt++;
        CK12_CE = ((ce_cnt % ce_div) == 0);
    end

    // Responder: DTAC low resp_delay ticks after AS falls, high one tick after AS rises
    int resp_delay = 1;
    bit stale      = 1'b0;
    int as_low     = 0;
    initial begin
        bus.DTAC = 1'b1;
        forever begin
            @(posedge SYSCLK);
            if (CK12_CE) begin
                #1;
                if (bus.AS == 1'b0) as_low++;
                else as_low = 0;
                if (stale) bus.DTAC = 1'b0;
                else if (bus.AS == 1'b0 && as_low >= resp_delay) bus.DTAC = 1'b0;
                else if (bus.AS == 1'b1) bus.DTAC = 1'b1;
            end
        end
    end

    // Scoreboard
    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          tout;
    } exp_t;
    exp_t sb[$];
    logic [DW-1:0] rd_model = '0;
    bit ack_prev  = 1'b0;
    int ack_count = 0;

    initial forever begin
        @(negedge SYSCLK);
        if (bus.ACK === 1'b1) begin
            ack_count++;
            check("ack_width", {31'd0, ack_prev}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ACK=1 expected no ACK (nothing pending)");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rdata", {24'd0, bus.RDATA}, {24'd0, e.rdata});
                check("tout", {31'd0, bus.TOUT}, {31'd0, e.tout});
            end
        end
        ack_prev = (bus.ACK === 1'b1);
    end

    bit            cur_we;
    logic [AW-1:0] cur_addr;
    bit            cur_bk;
    logic [DW-1:0] cur_wd;

    task automatic issue(input bit we, input logic [AW-1:0] a, input bit bk,
                         input logic [DW-1:0] wd, input logic [DW-1:0] din, input bit push);
        bus.REQ       = 1'b1;
        bus.REQ_WE    = we;
        bus.REQ_ADDR  = a;
        bus.REQ_BK4   = bk;
        bus.REQ_WDATA = wd;
        bus.DIN       = din;
        cur_we = we; cur_addr = a; cur_bk = bk; cur_wd = wd;
        if (push) begin
            if (!we) rd_model = din;
            sb.push_back('{rdata: rd_model, tout: 1'b0});
        end
    endtask

    // Waits for ACK; ok stays 1 while the bus fields match the request from AS fall to ACK
    task automatic wait_ack(input string name, input int maxc, output int lat, output bit ok);
        bit seen_low = 1'b0;
        lat = 0;
        ok  = 1'b1;
        while (1) begin
            @(negedge SYSCLK);
            lat++;
            if (bus.ACK === 1'b1) break;
            if (lat > maxc) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout: got no ACK after %0d cycles expected ACK", name, maxc);
                break;
            end
            if (bus.AS == 1'b0) seen_low = 1'b1;
            if (seen_low) begin
                if (bus.ADR !== cur_addr || bus.BK4 !== cur_bk || bus.RW !== !cur_we ||
                    bus.DOE !== cur_we || (cur_we && bus.DOUT !== cur_wd)) ok = 1'b0;
            end
        end
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_as"},    {31'd0, bus.AS},   32'd1);
        check({p, "_rw"},    {31'd0, bus.RW},   32'd1);
        check({p, "_doe"},   {31'd0, bus.DOE},  32'd0);
        check({p, "_ack"},   {31'd0, bus.ACK},  32'd0);
        check({p, "_tout"},  {31'd0, bus.TOUT}, 32'd0);
        check({p, "_adr"},   {16'd0, bus.ADR},  32'd0);
        check({p, "_bk4"},   {31'd0, bus.BK4},  32'd0);
        check({p, "_dout"},  {24'd0, bus.DOUT}, 32'd0);
        check({p, "_rdata"}, {24'd0, bus.RDATA}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit ok;
        int acks0;
        bus.REQ = 1'b0; bus.REQ_WE = 1'b0; bus.REQ_ADDR = '0;
        bus.REQ_BK4 = 1'b0; bus.REQ_WDATA = '0; bus.DIN = '0;

        repeat (4) @(negedge SYSCLK);
        check_reset_vals("reset");
        RESET = 1'b0;
        @(negedge SYSCLK);

        // Minimum-latency read
        issue(1'b0, 16'h5F80, 1'b0, 8'h00, 8'hA5, 1'b1);
        wait_ack("rd", 50, lat, ok);
        bus.REQ = 1'b0;
        check("rd_latency", lat, 4);
        check("rd_bus", {31'd0, ok}, 32'd1);
        check("rd_rw", {31'd0, bus.RW}, 32'd1);
        check("rd_as_at_ack", {31'd0, bus.AS}, 32'd1);
        repeat (3) @(negedge SYSCLK);

        // Slow-tick write with a 3-tick responder
        ce_div = 4; resp_delay = 3;
        issue(1'b1, 16'h4000, 1'b1, 8'h3C, 8'h00, 1'b1);
        wait_ack("wr", 200, lat, ok);
        bus.REQ = 1'b0;
        check("wr_bus", {31'd0, ok}, 32'd1);
        check("wr_doe_at_ack", {31'd0, bus.DOE}, 32'd0);
        check("wr_bk4", {31'd0, bus.BK4}, 32'd1);
        check("wr_dout", {24'd0, bus.DOUT}, 32'h3C);
        @(negedge SYSCLK);
        check("wr_ack_pulse", {31'd0, bus.ACK}, 32'd0);
        repeat (8) @(negedge SYSCLK);

        // Back-to-back: REQ held through ACK with the next address
        ce_div = 1; resp_delay = 1;
        @(negedge SYSCLK);
        acks0 = ack_count;
        issue(1'b0, 16'h1234, 1'b0, 8'h00, 8'h5A, 1'b1);
        wait_ack("b2b1", 50, lat, ok);
        issue(1'b0, 16'h0010, 1'b0, 8'h00, 8'hC3, 1'b1);
        check("b2b_as_gap", {31'd0, bus.AS}, 32'd1);
        wait_ack("b2b2", 50, lat, ok);
        bus.REQ = 1'b0;
        check("b2b_latency", lat, 4);
        check("b2b_adr", {16'd0, bus.ADR}, 32'h0010);
        repeat (6) @(negedge SYSCLK);
        check("b2b_ack_count", ack_count - acks0, 2);

        // Stale DTAC low through SETUP, then released before the first WAIT sample
        resp_delay = 3;
        stale = 1'b1;
        bus.DTAC = 1'b0;
        @(negedge SYSCLK);
        issue(1'b0, 16'h2222, 1'b0, 8'h00, 8'h77, 1'b1);
        @(negedge SYSCLK);
        @(negedge SYSCLK);
        check("stale_as_fall", {31'd0, bus.AS}, 32'd0);
        stale = 1'b0;
        bus.DTAC = 1'b1;
        @(negedge SYSCLK);
        check("stale_no_early", {31'd0, bus.AS}, 32'd0);
        wait_ack("stale", 50, lat, ok);
        bus.REQ = 1'b0;
        check("stale_bus", {31'd0, ok}, 32'd1);
        repeat (3) @(negedge SYSCLK);

        // Reset in WAIT with AS low
        resp_delay = 1000;
        issue(1'b1, 16'h5555, 1'b1, 8'h99, 8'h00, 1'b0);
        for (int i = 0; i < 10 && bus.AS !== 1'b0; i++) @(negedge SYSCLK);
        check("rst_as_low", {31'd0, bus.AS}, 32'd0);
        repeat (2) @(negedge SYSCLK);
        RESET = 1'b1;
        bus.REQ = 1'b0;
        @(negedge SYSCLK);
        check_reset_vals("midrst");
        RESET = 1'b0;
        rd_model = '0;
        resp_delay = 1;
        @(negedge SYSCLK);
        issue(1'b0, 16'h0ABC, 1'b0, 8'h00, 8'h3E, 1'b1);
        wait_ack("postrst", 50, lat, ok);
        bus.REQ = 1'b0;
        check("postrst_latency", lat, 4);
        repeat (3) @(negedge SYSCLK);

        // Responder never answers a read
        resp_delay = 1000;
`ifdef KONAMI2_INIT_TIMEOUT_EN
        issue(1'b0, 16'h0F0F, 1'b0, 8'h00, 8'h12, 1'b0);
        rd_model = 8'hFF;
        sb.push_back('{rdata: 8'hFF, tout: 1'b1});
        wait_ack("tmo", 50, lat, ok);
        bus.REQ = 1'b0;
        check("tmo_latency", lat, 11);
        check("tmo_as", {31'd0, bus.AS}, 32'd1);
        repeat (3) @(negedge SYSCLK);
        resp_delay = 1;
        issue(1'b0, 16'h0F10, 1'b0, 8'h00, 8'h44, 1'b1);
        wait_ack("tmo_next", 50, lat, ok);
        bus.REQ = 1'b0;
`else
        issue(1'b0, 16'h0F0F, 1'b0, 8'h00, 8'h12, 1'b0);
        repeat (40) @(negedge SYSCLK);
        check("hang_as", {31'd0, bus.AS}, 32'd0);
        check("hang_tout", {31'd0, bus.TOUT}, 32'd0);
        RESET = 1'b1;
        bus.REQ = 1'b0;
        @(negedge SYSCLK);
        check_reset_vals("hangrst");
        RESET = 1'b0;
        rd_model = '0;
        resp_delay = 1;
        @(negedge SYSCLK);
        issue(1'b0, 16'h0F10, 1'b0, 8'h00, 8'h44, 1'b1);
        wait_ack("hang_next", 50, lat, ok);
        bus.REQ = 1'b0;
        check("hang_next_latency", lat, 4);
`endif
        repeat (4) @(negedge SYSCLK);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
